memory_dp: RTL and testbench

Parametrised simple-dual-port RAM with lane (byte) write enables, registered read with valid flag, and a built-in clear sequencer that zeroes the array after reset. It is the general-purpose storage primitive for sprite, score and palette tables. Independent write and read ports allow a producer (bus-side writer) and a consumer (display pipeline) to share one array in the same cycle.

---
 rtl/memory_dp_if.sv | 29 ++
 rtl/memory_dp.sv | 98 +++++++++
 tb/tb_memory_dp.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/memory_dp_if.sv
// Bus bundle for memory_dp: write port, read port and the ready flag.
// The master drives accesses; the slave (the RAM) returns read data, rvalid and ready.
interface memory_dp_if #(
    parameter int WORD_SIZE = 16,
    parameter int LANE_SIZE = 8,
    parameter int ADDR_BITS = 4
) ();
    localparam int NUM_LANES = WORD_SIZE / LANE_SIZE;

    logic                 we;
    logic [ADDR_BITS-1:0] waddr;
    logic [NUM_LANES-1:0] wlane;
    logic [WORD_SIZE-1:0] data_in;
    logic                 re;
    logic [ADDR_BITS-1:0] raddr;
    logic [WORD_SIZE-1:0] data_out;
    logic                 rvalid;
    logic                 ready;

    modport master (
        output we, waddr, wlane, data_in, re, raddr,
        input  data_out, rvalid, ready
    );

    modport slave (
        input  we, waddr, wlane, data_in, re, raddr,
        output data_out, rvalid, ready
    );
endinterface

// File: rtl/memory_dp.sv
// Simple-dual-port RAM with lane write enables, registered read and a post-reset clear sweep.
// Optional macro MEMORY_BYPASS_EN: same-address write/read collisions return the merged new word.
module memory_dp #(
    parameter int WORD_SIZE = 16,
    parameter int LANE_SIZE = 8,
    parameter int NUM_WORDS = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    memory_dp_if.slave   bus
);
    localparam int                   NUM_LANES = WORD_SIZE / LANE_SIZE;
    localparam logic [ADDR_BITS:0]   WORDS_EXT = (ADDR_BITS + 1)'(NUM_WORDS);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_WORDS - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t               state, state_nxt;
    logic [ADDR_BITS-1:0] sweep;
    logic [WORD_SIZE-1:0] mem [NUM_WORDS];

    logic                 run;
    logic                 wr_inrange;
    logic                 rd_inrange;
    logic [NUM_LANES-1:0] wr_lane;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [WORD_SIZE-1:0] wr_data;
    logic [WORD_SIZE-1:0] rd_word;
    logic [WORD_SIZE-1:0] data_p1;
    logic                 vld_p1;

    function automatic logic [WORD_SIZE-1:0] merge_lanes(
        input logic [WORD_SIZE-1:0] old_w,
        input logic [WORD_SIZE-1:0] new_w,
        input logic [NUM_LANES-1:0] mask
    );
        logic [WORD_SIZE-1:0] res;
        res = old_w;
        for (int i = 0; i < NUM_LANES; i++)
            if (mask[i]) res[i*LANE_SIZE +: LANE_SIZE] = new_w[i*LANE_SIZE +: LANE_SIZE];
        return res;
    endfunction

    // Single physical write port: the sweep owns it in CLEAR, the bus in RUN.
    always_comb begin
        state_nxt  = state;
        run        = (state == RUN);
        wr_inrange = {1'b0, bus.waddr} < WORDS_EXT;
        rd_inrange = {1'b0, bus.raddr} < WORDS_EXT;
        wr_lane    = '0;
        wr_addr    = bus.waddr;
        wr_data    = bus.data_in;
        rd_word    = '0;
        case (state)
            CLEAR: begin
                wr_lane = '1;
                wr_addr = sweep;
                wr_data = '0;
                if (sweep == LAST_ADDR) state_nxt = RUN;
            end
            RUN: begin
                if (bus.we && wr_inrange) wr_lane = bus.wlane;
            end
            default: state_nxt = CLEAR;
        endcase
        if (rd_inrange) rd_word = mem[bus.raddr];
`ifdef MEMORY_BYPASS_EN
        if (run && bus.we && bus.re && (bus.waddr == bus.raddr))
            rd_word = merge_lanes(rd_word, bus.data_in, wr_lane);
`endif
    end

    // Stage p1: registered read data and its valid flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= CLEAR;
            sweep   <= '0;
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            state  <= state_nxt;
            if (state == CLEAR) sweep <= sweep + 1'b1;
            vld_p1 <= run && bus.re;
            if (run && bus.re) data_p1 <= rd_word;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++)
            if (wr_lane[i])
                mem[wr_addr][i*LANE_SIZE +: LANE_SIZE] <= wr_data[i*LANE_SIZE +: LANE_SIZE];
    end

    assign bus.data_out = data_p1;
    assign bus.rvalid   = vld_p1;
    assign bus.ready    = run;
endmodule

// File: tb/tb_memory_dp.sv
// Self-checking bench for memory_dp: vector table plus scoreboard-tracked reads,
// with hand-written sequences for the clear sweep, streaming, out-of-range and mid-sweep reset.
module tb_memory_dp;
    typedef struct {
        logic        we;
        logic [3:0]  waddr;
        logic [1:0]  wlane;
        logic [15:0] din;
        logic        re;
        logic [3:0]  raddr;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        int          due;
    } sb_t;

`ifdef MEMORY_BYPASS_EN
    localparam logic [15:0] COL1 = 16'hBEEF;
    localparam logic [15:0] COL2 = 16'hBE77;
`else
    localparam logic [15:0] COL1 = 16'h1111;
    localparam logic [15:0] COL2 = 16'hBEEF;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    sb_t  q[$];
    sb_t  mon_e;
    vec_t vt [14];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memory_dp_if #(.WORD_SIZE(16), .LANE_SIZE(8), .ADDR_BITS(4)) bus  ();
    memory_dp_if #(.WORD_SIZE(16), .LANE_SIZE(8), .ADDR_BITS(4)) bus2 ();

    memory_dp #(.WORD_SIZE(16), .LANE_SIZE(8), .NUM_WORDS(16), .ADDR_BITS(4)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    memory_dp #(.WORD_SIZE(16), .LANE_SIZE(8), .NUM_WORDS(12), .ADDR_BITS(4)) dut_s (
        .clk(clk), .reset_n(reset_n), .bus(bus2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we = 1'b0; bus.waddr = '0; bus.wlane = '0; bus.data_in = '0;
        bus.re = 1'b0; bus.raddr = '0;
    endtask

    task automatic step(input vec_t v);
        sb_t e;
        bus.we = v.we; bus.waddr = v.waddr; bus.wlane = v.wlane; bus.data_in = v.din;
        bus.re = v.re; bus.raddr = v.raddr;
        if (v.re) begin
            e.data = v.exp;
            e.due  = cyc + 1;
            q.push_back(e);
        end
        tick();
    endtask

    task automatic s_step(input logic we, input logic [3:0] wa, input logic [15:0] d,
                          input logic re, input logic [3:0] ra);
        bus2.we = we; bus2.waddr = wa; bus2.wlane = 2'b11; bus2.data_in = d;
        bus2.re = re; bus2.raddr = ra;
        tick();
    endtask

    task automatic read_all_zero();
        vec_t v;
        for (int a = 0; a < 16; a++) begin
            v = '{1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'(a), 16'h0000};
            step(v);
        end
        idle();
        tick();
    endtask

    // Every cycle: rvalid must pulse exactly when a queued read falls due.
    always @(negedge clk) begin
        if (q.size() != 0 && q[0].due == cyc) begin
            chk("rvalid", {31'b0, bus.rvalid}, 32'd1);
            mon_e = q.pop_front();
            chk("rdata", {16'b0, bus.data_out}, {16'b0, mon_e.data});
        end else begin
            chk("rvalid_idle", {31'b0, bus.rvalid}, 32'd0);
        end
    end

    initial begin
        vec_t v;
        vt[0]  = '{1'b1, 4'd3, 2'b11, 16'hFFFF, 1'b0, 4'd0, 16'h0000};
        vt[1]  = '{1'b1, 4'd3, 2'b01, 16'h12AB, 1'b0, 4'd0, 16'h0000};
        vt[2]  = '{1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd3, 16'hFFAB};
        vt[3]  = '{1'b1, 4'd7, 2'b10, 16'h5A00, 1'b1, 4'd3, 16'hFFAB};
        vt[4]  = '{1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd7, 16'h5A00};
        vt[5]  = '{1'b1, 4'd7, 2'b00, 16'hFFFF, 1'b1, 4'd0, 16'h0000};
        vt[6]  = '{1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd7, 16'h5A00};
        vt[7]  = '{1'b1, 4'd5, 2'b11, 16'h1111, 1'b0, 4'd0, 16'h0000};
        vt[8]  = '{1'b1, 4'd5, 2'b11, 16'hBEEF, 1'b1, 4'd5, COL1};
        vt[9]  = '{1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd5, 16'hBEEF};
        vt[10] = '{1'b1, 4'd5, 2'b01, 16'h0077, 1'b1, 4'd5, COL2};
        vt[11] = '{1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd5, 16'hBE77};
        vt[12] = '{1'b1, 4'd2, 2'b11, 16'h0042, 1'b1, 4'd3, 16'hFFAB};
        vt[13] = '{1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd2, 16'h0042};

        reset_n = 1'b0;
        idle();
        bus2.we = 1'b0; bus2.waddr = '0; bus2.wlane = '0; bus2.data_in = '0;
        bus2.re = 1'b0; bus2.raddr = '0;
        tick();
        tick();
        chk("rst_ready", {31'b0, bus.ready}, 32'd0);
        chk("rst_dout", {16'b0, bus.data_out}, 32'd0);
        chk("rst_ready_s", {31'b0, bus2.ready}, 32'd0);

        // Clear sweep with user traffic that must be ignored.
        reset_n = 1'b1;
        bus.we = 1'b1; bus.waddr = 4'd0; bus.wlane = 2'b11; bus.data_in = 16'hFFFF;
        bus.re = 1'b1; bus.raddr = 4'd0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("sweep_ready", {31'b0, bus.ready}, {31'b0, (k == 16)});
            chk("sweep_ready_s", {31'b0, bus2.ready}, {31'b0, (k >= 12)});
        end
        idle();
        read_all_zero();

        for (int i = 0; i < 14; i++) step(vt[i]);
        idle();
        tick();

        // Streaming: preload then eight back-to-back reads.
        for (int i = 0; i < 8; i++) begin
            v = '{1'b1, 4'(i), 2'b11, 16'h0100 + 16'(i), 1'b0, 4'd0, 16'h0};
            step(v);
        end
        for (int i = 0; i < 8; i++) begin
            v = '{1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'(i), 16'h0100 + 16'(i)};
            step(v);
        end
        idle();
        tick();
        chk("stream_end_vld", {31'b0, bus.rvalid}, 32'd0);
        chk("stream_hold", {16'b0, bus.data_out}, 32'h0107);
        tick();
        chk("stream_hold2", {16'b0, bus.data_out}, 32'h0107);

        // Out-of-range accesses on the 12-word instance.
        s_step(1'b1, 4'd11, 16'h5555, 1'b0, 4'd0);
        s_step(1'b1, 4'd13, 16'hAAAA, 1'b0, 4'd0);
        s_step(1'b0, 4'd0, 16'h0, 1'b1, 4'd11);
        chk("s_rd11_vld", {31'b0, bus2.rvalid}, 32'd1);
        chk("s_rd11", {16'b0, bus2.data_out}, 32'h5555);
        s_step(1'b0, 4'd0, 16'h0, 1'b1, 4'd13);
        chk("s_oor_vld", {31'b0, bus2.rvalid}, 32'd1);
        chk("s_oor_data", {16'b0, bus2.data_out}, 32'h0);
        s_step(1'b0, 4'd0, 16'h0, 1'b1, 4'd1);
        chk("s_rd1", {16'b0, bus2.data_out}, 32'h0);
        s_step(1'b0, 4'd0, 16'h0, 1'b1, 4'd11);
        chk("s_rd11_again", {16'b0, bus2.data_out}, 32'h5555);
        s_step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
        chk("s_idle_vld", {31'b0, bus2.rvalid}, 32'd0);
        chk("s_idle_hold", {16'b0, bus2.data_out}, 32'h5555);

        // Reset during the sweep restarts it from address 0.
        v = '{1'b1, 4'd9, 2'b11, 16'hDEAD, 1'b0, 4'd0, 16'h0};
        step(v);
        idle();
        reset_n = 1'b0;
        #1;
        chk("arst_dout", {16'b0, bus.data_out}, 32'd0);
        chk("arst_ready", {31'b0, bus.ready}, 32'd0);
        chk("arst_dout_s", {16'b0, bus2.data_out}, 32'd0);
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 7; k++) tick();
        #1 reset_n = 1'b0;
        #1 reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("resweep_ready", {31'b0, bus.ready}, {31'b0, (k == 16)});
        end
        read_all_zero();

        tick();
        chk("sb_drain", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
